tetris_line_clear: RTL and testbench
====================================

TETRIS_LINE_CLEAR -- requirements
Module: tetris_line_clear

Interface
REQ-001 SHALL have parameter GameWidth, default 10, cells per board row.
REQ-002 SHALL have parameter GameHeight, default 20, board rows; row 0 is the bottom row.
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  input  1  request one clear pass; sampled only in IDLE.
REQ-006 SHALL have port busy  output  1  high from the cycle after start is accepted until done.
REQ-007 SHALL have port done  output  1  one-cycle pulse at the end of a pass.
REQ-008 SHALL have port lines_cleared  output  3  full rows removed in the last pass (0-4); held until the next done.
REQ-009 SHALL have port ram_addr  output  12  board RAM address, y*GameWidth+x.
REQ-010 SHALL have port ram_we  output  1  board RAM write enable.
REQ-011 SHALL have port ram_wdata  output  3  cell value to write.
REQ-012 SHALL have port ram_rdata  input  3  cell value; valid one cycle after ram_addr is driven (synchronous read).
REQ-013 SHALL have port score  output  16  accumulated score (see Configuration).

Function
REQ-014 SHALL treat a cell as occupied when its value is nonzero.
REQ-015 SHALL use the states IDLE, SCAN, SHIFT, CLEAR_TOP and FINISH.
REQ-016 IDLE -> SCAN on start=1: row pointer 0, lines counter 0, busy asserted.
REQ-017 SCAN: read cells x=0..GameWidth-1 of the current row, one address per cycle, with a one-cycle read latency per row.
REQ-018 SCAN: any empty cell ends the row scan early; the row pointer then increments.
REQ-019 SCAN: when all GameWidth cells are occupied, the lines counter SHALL increment and the state SHALL go to SHIFT.
REQ-020 SHIFT: for each row r from the current row up to GameHeight-2, each cell (x,r+1) SHALL be read and its value written to (x,r); each cell is read, then written one cycle after the read.
REQ-021 CLEAR_TOP: write 0 to all GameWidth cells of row GameHeight-1, then return to SCAN on the same row pointer, because the shifted-down row must be re-checked.
REQ-022 SCAN with row pointer = GameHeight SHALL go to FINISH.
REQ-023 FINISH: pulse done for one cycle, load lines_cleared, deassert busy, go to IDLE.
REQ-024 ram_we SHALL be high only in SHIFT write cycles and in CLEAR_TOP.
REQ-025 ram_addr SHALL never exceed GameWidth*GameHeight-1.
REQ-026 start while busy SHALL be ignored and SHALL NOT be queued.
REQ-027 A board with no full rows SHALL leave RAM unmodified.
REQ-028 A board with no full rows SHALL give done within GameHeight*(GameWidth+1)+4 cycles of start.
REQ-029 The lines counter SHALL saturate at 4.

Reset
REQ-030 While reset=1, outputs SHALL be asynchronously forced to: state IDLE, busy=0, done=0, ram_we=0, ram_addr=0, ram_wdata=0, lines_cleared=0, score=0.
REQ-031 Reset during a pass SHALL abandon the pass with no further RAM writes; a partially shifted board is acceptable.
REQ-032 After reset deasserts, the block SHALL accept start on the first rising edge.

Configuration
REQ-033 With macro LINE_CLEAR_SCORE_EN defined, score SHALL add 1/3/5/8 for 1/2/3/4 lines at each done and saturate at 65535.
REQ-034 Without LINE_CLEAR_SCORE_EN, score SHALL be the constant 0 and no score logic SHALL be built.

Verification
REQ-035 Empty board, start -> done within 224 cycles, lines_cleared=0, ram_we never high.
REQ-036 Row 0 full (all 3), row 1 cell x=2 holds 5, start -> row 0 becomes 0,0,5,0..., row 1 all 0, lines_cleared=1, score=1 with LINE_CLEAR_SCORE_EN.
REQ-037 Rows 0-3 full, rest empty, start -> entire board 0, lines_cleared=4, score=8.
REQ-038 Row 19 full, start -> row 19 all 0, lines_cleared=1; row 19 write addresses range 190-199 only.
REQ-039 Reset asserted 30 cycles into a SHIFT -> busy=0 and ram_we=0 in the same cycle; a new start then completes normally.
REQ-040 start pulsed again while busy -> exactly one done pulse results.

Source files
------------

// File: rtl/tetris_line_clear_if.sv
// Board-clear controller bus: start/busy/done handshake, result outputs and the
// synchronous-read board RAM port. The slave modport is the clear engine; the
// master modport is the host side (game controller plus board RAM).
interface tetris_line_clear_if;
    logic        start;
    logic        busy;
    logic        done;
    logic [2:0]  lines_cleared;
    logic [11:0] ram_addr;
    logic        ram_we;
    logic [2:0]  ram_wdata;
    logic [2:0]  ram_rdata;
    logic [15:0] score;

    modport master (
        output start, ram_rdata,
        input  busy, done, lines_cleared, ram_addr, ram_we, ram_wdata, score
    );

    modport slave (
        input  start, ram_rdata,
        output busy, done, lines_cleared, ram_addr, ram_we, ram_wdata, score
    );
endinterface

// File: rtl/tetris_line_clear.sv
// Line-clear engine for a GameWidth x GameHeight board held in an external RAM
// with one-cycle read latency. One pass scans rows bottom-up, collapses every
// full row by copying all rows above it down by one, blanks the top row and
// re-checks the same row. Optional scoring is built only when the macro
// LINE_CLEAR_SCORE_EN is defined; otherwise score is tied to zero.
module tetris_line_clear #(
    parameter int GameWidth  = 10,
    parameter int GameHeight = 20
) (
    input  logic               clk,
    input  logic               reset,
    tetris_line_clear_if.slave bus
);
    localparam int RW = $clog2(GameHeight + 1);
    localparam int XW = $clog2(GameWidth + 1);

    localparam logic [RW-1:0] ROW_END        = RW'(GameHeight);
    localparam logic [RW-1:0] ROW_TOP        = RW'(GameHeight - 1);
    localparam logic [RW-1:0] ROW_SHIFT_LAST = RW'(GameHeight - 2);
    localparam logic [XW-1:0] X_END          = XW'(GameWidth);
    localparam logic [XW-1:0] X_LAST         = XW'(GameWidth - 1);

    typedef enum logic [2:0] {IDLE, SCAN, SHIFT, CLEAR_TOP, FINISH} state_e;

    state_e        state_q, state_d;
    logic [RW-1:0] row_q, row_d;     // row being scanned
    logic [RW-1:0] sr_q, sr_d;       // destination row while shifting
    logic [XW-1:0] x_q, x_d;         // column being addressed
    logic          vld_q, vld_d;     // ram_rdata holds the cell at column x_q-1
    logic          wr_q, wr_d;       // SHIFT phase: 0 = read above, 1 = write here
    logic [2:0]    lines_q, lines_d;
    logic [2:0]    lines_cleared_q;
    logic          pass_end;

    function automatic logic [11:0] cell_addr(input logic [RW-1:0] r, input logic [XW-1:0] x);
        return 12'(int'(r) * GameWidth + int'(x));
    endfunction

    assign pass_end = (state_q == SCAN) && (row_q == ROW_END);

    // State and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= IDLE;
            row_q           <= '0;
            sr_q            <= '0;
            x_q             <= '0;
            vld_q           <= 1'b0;
            wr_q            <= 1'b0;
            lines_q         <= '0;
            lines_cleared_q <= '0;
        end else begin
            // NOTE: non-blocking so every register updates from pre-edge values.
            state_q <= state_d;
            row_q   <= row_d;
            sr_q    <= sr_d;
            x_q     <= x_d;
            vld_q   <= vld_d;
            wr_q    <= wr_d;
            lines_q <= lines_d;
            if (pass_end) lines_cleared_q <= lines_q;
        end
    end

    // Next-state and counter sequencing.
    always_comb begin
        // NOTE: hold-value defaults first so no branch leaves a variable unassigned (no latches).
        state_d = state_q;
        row_d   = row_q;
        sr_d    = sr_q;
        x_d     = x_q;
        vld_d   = vld_q;
        wr_d    = wr_q;
        lines_d = lines_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = SCAN;
                    row_d   = '0;
                    x_d     = '0;
                    vld_d   = 1'b0;
                    lines_d = '0;
                end
            end
            SCAN: begin
                if (row_q == ROW_END) begin
                    state_d = FINISH;
                end else if (vld_q && (bus.ram_rdata == 3'd0)) begin
                    // An empty cell settles the row; move up.
                    row_d = row_q + RW'(1);
                    x_d   = '0;
                    vld_d = 1'b0;
                end else if (x_q == X_END) begin
                    // Last cell arrived occupied: the row is full.
                    lines_d = (lines_q == 3'd4) ? lines_q : lines_q + 3'd1;
                    x_d     = '0;
                    vld_d   = 1'b0;
                    wr_d    = 1'b0;
                    sr_d    = row_q;
                    state_d = (row_q == ROW_TOP) ? CLEAR_TOP : SHIFT;
                end else begin
                    x_d   = x_q + XW'(1);
                    vld_d = 1'b1;
                end
            end
            SHIFT: begin
                wr_d = ~wr_q;
                if (wr_q) begin
                    if (x_q == X_LAST) begin
                        x_d = '0;
                        if (sr_q == ROW_SHIFT_LAST) state_d = CLEAR_TOP;
                        else                        sr_d    = sr_q + RW'(1);
                    end else begin
                        x_d = x_q + XW'(1);
                    end
                end
            end
            CLEAR_TOP: begin
                if (x_q == X_LAST) begin
                    // Re-check the same row: it now holds what was above it.
                    x_d     = '0;
                    vld_d   = 1'b0;
                    state_d = SCAN;
                end else begin
                    x_d = x_q + XW'(1);
                end
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs decoded from the registered state; reset forces all of them idle at once.
    always_comb begin
        bus.busy      = (state_q == SCAN) || (state_q == SHIFT) || (state_q == CLEAR_TOP);
        bus.done      = (state_q == FINISH);
        bus.ram_addr  = '0;
        bus.ram_we    = 1'b0;
        bus.ram_wdata = '0;
        case (state_q)
            SCAN: begin
                if ((row_q != ROW_END) && (x_q != X_END)) bus.ram_addr = cell_addr(row_q, x_q);
            end
            SHIFT: begin
                if (wr_q) begin
                    bus.ram_addr  = cell_addr(sr_q, x_q);
                    bus.ram_we    = 1'b1;
                    bus.ram_wdata = bus.ram_rdata;
                end else begin
                    bus.ram_addr = cell_addr(sr_q + RW'(1), x_q);
                end
            end
            CLEAR_TOP: begin
                bus.ram_addr = cell_addr(ROW_TOP, x_q);
                bus.ram_we   = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.lines_cleared = lines_cleared_q;

`ifdef LINE_CLEAR_SCORE_EN
    logic [15:0] score_q, score_d, bonus;
    logic [16:0] sum;

    // Score update at the end of each pass, saturating at the 16-bit maximum.
    always_comb begin
        case (lines_q)
            3'd1:    bonus = 16'd1;
            3'd2:    bonus = 16'd3;
            3'd3:    bonus = 16'd5;
            3'd4:    bonus = 16'd8;
            default: bonus = 16'd0;
        endcase
        sum     = {1'b0, score_q} + {1'b0, bonus};
        score_d = score_q;
        if (pass_end) score_d = sum[16] ? 16'hFFFF : sum[15:0];
    end

    // Score register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) score_q <= '0;
        else       score_q <= score_d;
    end

    assign bus.score = score_q;
`else
    assign bus.score = '0;
`endif
endmodule

// File: tb/tb_tetris_line_clear.sv
// Directed bench for tetris_line_clear on a 10x20 board: a table of board
// set-ups with hand-derived results, plus sequences for start-while-busy,
// reset during a shift, and score/lines_cleared carried across passes.
module tb_tetris_line_clear;
    localparam int W     = 10;
    localparam int H     = 20;
    localparam int CELLS = W * H;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    tetris_line_clear_if bus();

    tetris_line_clear #(.GameWidth(W), .GameHeight(H)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    // Board RAM: synchronous read, old data returned on a same-cycle write.
    logic [2:0] mem [CELLS];
    always @(posedge clk) begin
        bus.ram_rdata <= (bus.ram_addr < 12'(CELLS)) ? mem[bus.ram_addr] : 3'd0;
        if (bus.ram_we && (bus.ram_addr < 12'(CELLS))) mem[bus.ram_addr] = bus.ram_wdata;
    end

    // Activity monitor, sampled mid-cycle.
    int wr_cnt, wmin, done_cnt, addr_viol;
    always @(negedge clk) begin
        if (!reset) begin
            if (bus.ram_we) begin
                wr_cnt++;
                if (int'(bus.ram_addr) < wmin) wmin = int'(bus.ram_addr);
            end
            if (bus.ram_addr >= 12'(CELLS)) addr_viol++;
            if (bus.done) done_cnt++;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    typedef struct {
        logic [19:0] full_mask;   // rows completely filled with fill
        logic [2:0]  fill;
        int          part_row;    // row with cells x < part_len set to fill
        int          part_len;
        int          ex_addr;     // one extra cell (ex_val 0 = none)
        int          ex_val;
        int          exp_part_row;
        int          exp_part_len;
        int          exp_ex_addr;
        int          exp_ex_val;
        int          exp_lines;
        int          exp_score;   // score after this pass when scoring is built
        int          exp_writes;
        int          exp_wmin;
        int          max_cycles;
    } vec_t;

    function automatic vec_t mk(logic [19:0] fm, logic [2:0] fill, int pr, int pl, int ea, int ev,
                                int epr, int epl, int eea, int eev, int el, int es, int ew,
                                int ewm, int mc);
        vec_t v;
        v.full_mask = fm;   v.fill = fill;  v.part_row = pr;  v.part_len = pl;
        v.ex_addr = ea;     v.ex_val = ev;  v.exp_part_row = epr; v.exp_part_len = epl;
        v.exp_ex_addr = eea; v.exp_ex_val = eev; v.exp_lines = el; v.exp_score = es;
        v.exp_writes = ew;  v.exp_wmin = ewm; v.max_cycles = mc;
        return v;
    endfunction

    function automatic int score_of(input int s);
`ifdef LINE_CLEAR_SCORE_EN
        return s;
`else
        return s * 0;
`endif
    endfunction

    task automatic load_board(input vec_t v);
        for (int i = 0; i < CELLS; i++) mem[i] = 3'd0;
        for (int r = 0; r < H; r++)
            if (v.full_mask[r]) for (int x = 0; x < W; x++) mem[r * W + x] = v.fill;
        for (int x = 0; x < v.part_len; x++) mem[v.part_row * W + x] = v.fill;
        if (v.ex_val != 0) mem[v.ex_addr] = 3'(v.ex_val);
    endtask

    task automatic check_board(input string name, input vec_t v);
        logic [2:0] want;
        int bad = 0;
        int first = -1;
        logic [2:0] first_got = 3'd0;
        logic [2:0] first_want = 3'd0;
        for (int i = 0; i < CELLS; i++) begin
            want = 3'd0;
            if ((i / W == v.exp_part_row) && (i % W < v.exp_part_len)) want = v.fill;
            if ((v.exp_ex_val != 0) && (i == v.exp_ex_addr)) want = 3'(v.exp_ex_val);
            if (mem[i] !== want) begin
                bad++;
                if (first < 0) begin first = i; first_got = mem[i]; first_want = want; end
            end
        end
        check(name, bad, 0);
        if (bad != 0) $display("  first differing cell %0d holds %0d, wanted %0d", first, first_got, first_want);
    endtask

    task automatic clear_counters();
        wr_cnt = 0; wmin = 1 << 30; done_cnt = 0;
    endtask

    // Enter reset at a falling edge and confirm every output is forced idle.
    task automatic do_reset(input string tag);
        reset = 1'b1;
        bus.start = 1'b0;
        #1;
        check({tag, "_rst_ctrl"}, 32'({bus.busy, bus.done, bus.ram_we, bus.ram_wdata, bus.lines_cleared}), 32'd0);
        check({tag, "_rst_addr"}, 32'(bus.ram_addr), 32'd0);
        check({tag, "_rst_score"}, 32'(bus.score), 32'd0);
        repeat (2) @(negedge clk);
    endtask

    task automatic kick();
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int max_cycles);
        int n = 0;
        while ((bus.done !== 1'b1) && (n < max_cycles)) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(bus.done === 1'b1), 32'd1);
    endtask

    vec_t vecs[9];
    int   snap;

    initial begin
        bus.start = 1'b0;
        reset     = 1'b1;
        addr_viol = 0;
        clear_counters();

        vecs[0] = mk(20'h00000, 3'd3, 0, 0,   0, 0, 0, 0,  0, 0, 0, 0,    0,   0,  224); // empty board
        vecs[1] = mk(20'h00001, 3'd3, 0, 0,  12, 5, 0, 0,  2, 5, 1, 1,  200,   0, 5000); // row 0 full, (2,1)=5
        vecs[2] = mk(20'h0000F, 3'd3, 0, 0,   0, 0, 0, 0,  0, 0, 4, 8,  800,   0, 5000); // rows 0-3 full
        vecs[3] = mk(20'h80000, 3'd3, 0, 0,   0, 0, 0, 0,  0, 0, 1, 1,   10, 190, 5000); // top row full
        vecs[4] = mk(20'h00000, 3'd3, 5, 9,   0, 0, 5, 9,  0, 0, 0, 0,    0,   0,  224); // row 5 one short
        vecs[5] = mk(20'h0001F, 3'd6, 0, 0,   0, 0, 0, 0,  0, 0, 4, 8, 1000,   0, 5000); // 5 full: saturate at 4
        vecs[6] = mk(20'h00005, 3'd7, 1, 3,  37, 1, 0, 3, 17, 1, 2, 3,  390,   0, 5000); // gapped full rows
        vecs[7] = mk(20'hC0000, 3'd2, 0, 0,   0, 0, 0, 0,  0, 0, 2, 3,   40, 180, 5000); // rows 18,19 full
        vecs[8] = mk(20'h00380, 3'd4, 0, 0, 100, 7, 0, 0, 70, 7, 3, 5,  390,  70, 5000); // rows 7-9 full

        @(negedge clk);
        for (int i = 0; i < 9; i++) begin
            string t;
            t = $sformatf("v%0d", i);
            do_reset(t);
            load_board(vecs[i]);
            clear_counters();
            reset = 1'b0;
            kick();                                  // start on the first edge after reset
            check({t, "_busy"}, 32'(bus.busy), 32'd1);
            wait_done({t, "_done"}, vecs[i].max_cycles);
            check({t, "_lines"}, 32'(bus.lines_cleared), 32'(vecs[i].exp_lines));
            check({t, "_score"}, 32'(bus.score), 32'(score_of(vecs[i].exp_score)));
            @(negedge clk);
            check({t, "_idle"}, 32'({bus.busy, bus.done}), 32'd0);
            repeat (3) @(negedge clk);
            check({t, "_done_count"}, done_cnt, 1);
            check({t, "_writes"}, wr_cnt, vecs[i].exp_writes);
            if (vecs[i].exp_writes != 0) check({t, "_wmin"}, wmin, vecs[i].exp_wmin);
            check_board({t, "_board"}, vecs[i]);
        end

        // start re-pulsed while busy and during the done cycle: one pass, one done.
        do_reset("dbl");
        load_board(vecs[1]);
        clear_counters();
        reset = 1'b0;
        kick();
        for (int n = 1; (bus.done !== 1'b1) && (n < 5000); n++) begin
            bus.start = (n == 5) || (n == 100);
            @(negedge clk);
        end
        bus.start = 1'b0;
        check("dbl_done", 32'(bus.done === 1'b1), 32'd1);
        bus.start = 1'b1;                            // sampled in FINISH, must be dropped
        @(negedge clk);
        bus.start = 1'b0;
        repeat (50) @(negedge clk);
        check("dbl_done_count", done_cnt, 1);
        check("dbl_busy", 32'(bus.busy), 32'd0);
        check("dbl_lines", 32'(bus.lines_cleared), 32'd1);
        check_board("dbl_board", vecs[1]);

        // Reset 30 cycles into a shift: pass abandoned at once, next pass is normal.
        do_reset("abort");
        load_board(vecs[1]);
        clear_counters();
        reset = 1'b0;
        kick();
        for (int n = 0; (bus.ram_we !== 1'b1) && (n < 100); n++) @(negedge clk);
        check("abort_shift_seen", 32'(bus.ram_we), 32'd1);
        repeat (30) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("abort_busy_we", 32'({bus.busy, bus.ram_we}), 32'd0);
        snap = wr_cnt;
        check("abort_writes_before", snap, 16);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        check("abort_no_writes", wr_cnt, snap);
        load_board(vecs[3]);
        clear_counters();
        kick();
        wait_done("abort_rerun_done", 5000);
        check("abort_rerun_lines", 32'(bus.lines_cleared), 32'd1);
        @(negedge clk);
        check_board("abort_rerun_board", vecs[3]);

        // Score accumulates across passes; lines_cleared holds through the next pass.
        do_reset("acc");
        load_board(vecs[1]);
        clear_counters();
        reset = 1'b0;
        kick();
        wait_done("acc_first_done", 5000);
        @(negedge clk);
        load_board(vecs[2]);
        kick();
        repeat (20) @(negedge clk);
        check("acc_lines_held", 32'(bus.lines_cleared), 32'd1);
        wait_done("acc_second_done", 5000);
        check("acc_lines", 32'(bus.lines_cleared), 32'd4);
        check("acc_score", 32'(bus.score), 32'(score_of(9)));
        @(negedge clk);

        check("addr_range", addr_viol, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
